// File: rtl/coin_validator.sv
// -----------------------------------------------------------------------------
// coin_validator
//
// Measures how long a coin blocks the coin-path sensor and classifies it:
//   - 5-unit coin when the width is in [MIN5, MIN5..MAX5]
//   - 10-unit coin when the width is in [MIN10..MAX10]
//   - anything else, or any coin that arrives while inhibit is high, is
//     rejected
// A sensor that stays high for 255 cycles is reported as a jam. After every
// coin event the block locks out for GAP cycles.
//
// Parameters:
//   MIN5, MAX5   inclusive width range of a 5-unit coin (clk cycles)
//   MIN10, MAX10 inclusive width range of a 10-unit coin (clk cycles)
//   GAP          lockout cycles after each coin event (>= 1)
//   Supported values: 1 <= MIN5 <= MAX5 < MIN10 <= MAX10 < 255
//
// Ports:
//   clk        in   clock; all state changes on the rising edge
//   rst        in   asynchronous active-high reset
//   coin_sense in   raw asynchronous sensor, high while a coin passes
//   inhibit    in   synchronous; high = refuse coins (downstream busy)
//   in_code    out  [1:0] 00 none, 01 5-unit, 10 10-unit (one cycle)
//   reject     out  one-cycle pulse, coin returned
//   jam        out  level, sensor stuck high
//   busy       out  high whenever the FSM is not idle
//   cnt5       out  [7:0] saturating count of 5-unit coins  (COIN_AUDIT_EN)
//   cnt10      out  [7:0] saturating count of 10-unit coins (COIN_AUDIT_EN)
//
// Build option: define COIN_AUDIT_EN to add the cnt5/cnt10 audit counters.
//
// All outputs are registered. They are computed from the next state, so each
// one is valid in the same cycle as the state it describes (e.g. in_code is
// nonzero exactly while the FSM is in RESULT).
// -----------------------------------------------------------------------------
module coin_validator #(
  parameter int MIN5  = 4,
  parameter int MAX5  = 8,
  parameter int MIN10 = 12,
  parameter int MAX10 = 20,
  parameter int GAP   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_sense,
  input  logic       inhibit,
  output logic [1:0] in_code,
  output logic       reject,
  output logic       jam,
  output logic       busy
`ifdef COIN_AUDIT_EN
  ,
  output logic [7:0] cnt5,
  output logic [7:0] cnt10
`endif
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [7:0]    MIN5_W   = 8'(MIN5);
  localparam logic [7:0]    MAX5_W   = 8'(MAX5);
  localparam logic [7:0]    MIN10_W  = 8'(MIN10);
  localparam logic [7:0]    MAX10_W  = 8'(MAX10);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MEASURE,
    ST_RESULT,
    ST_GAP,
    ST_JAM
  } state_t;

  state_t        state_reg, state_next;
  logic [7:0]    width_reg, width_next;
  logic [GW-1:0] gap_reg, gap_next;
  logic [1:0]    sync_reg;
  logic          s_sense;
  logic [1:0]    code_next;
  logic          reject_next;

  // Two-flop synchronizer; only the second stage is used anywhere else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], coin_sense};
    end
  end

  assign s_sense = sync_reg[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      width_reg <= 8'd0;
      gap_reg   <= '0;
      in_code   <= 2'b00;
      reject    <= 1'b0;
      jam       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_reg <= state_next;
      width_reg <= width_next;
      gap_reg   <= gap_next;
      in_code   <= code_next;
      reject    <= reject_next;
      jam       <= (state_next == ST_JAM);
      busy      <= (state_next != ST_IDLE);
    end
  end

  always_comb begin
    state_next  = state_reg;
    width_next  = width_reg;
    gap_next    = gap_reg;
    code_next   = 2'b00;
    reject_next = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (s_sense) begin
          state_next = ST_MEASURE;
          width_next = 8'd1;
        end
      end

      ST_MEASURE: begin
        if (s_sense) begin
          width_next = width_reg + 8'd1;
          // The edge that brings the width to 255 while still covered is a jam.
          if (width_reg == 8'd254) begin
            state_next = ST_JAM;
          end
        end else begin
          state_next = ST_RESULT;
          width_next = 8'd0;
          if (inhibit) begin
            reject_next = 1'b1;
          end else if ((width_reg >= MIN5_W) && (width_reg <= MAX5_W)) begin
            code_next = 2'b01;
          end else if ((width_reg >= MIN10_W) && (width_reg <= MAX10_W)) begin
            code_next = 2'b10;
          end else begin
            reject_next = 1'b1;
          end
        end
      end

      ST_RESULT: begin
        state_next = ST_GAP;
        gap_next   = GAP_LOAD;
      end

      // The sensor is deliberately ignored here; a coin still present when
      // the lockout ends is picked up again from IDLE.
      ST_GAP: begin
        if (gap_reg == '0) begin
          state_next = ST_IDLE;
        end else begin
          gap_next = gap_reg - 1'b1;
        end
      end

      ST_JAM: begin
        if (!s_sense) begin
          state_next  = ST_GAP;
          gap_next    = GAP_LOAD;
          width_next  = 8'd0;
          reject_next = 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
        width_next = 8'd0;
      end
    endcase
  end

`ifdef COIN_AUDIT_EN
  // code_next is nonzero only on the transition into RESULT, so each
  // accepted coin is counted exactly once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt5  <= 8'd0;
      cnt10 <= 8'd0;
    end else begin
      if ((code_next == 2'b01) && (cnt5 != 8'hFF)) begin
        cnt5 <= cnt5 + 8'd1;
      end
      if ((code_next == 2'b10) && (cnt10 != 8'hFF)) begin
        cnt10 <= cnt10 + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_coin_validator.sv
module tb_coin_validator;

  localparam int GAP = 4;

  logic       clk;
  logic       rst;
  logic       coin_sense;
  logic       inhibit;
  logic [1:0] in_code;
  logic       reject;
  logic       jam;
  logic       busy;
`ifdef COIN_AUDIT_EN
  logic [7:0] cnt5;
  logic [7:0] cnt10;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Pulse monitor state (sampled on the falling edge)
  int cyc    = 0;
  int n5     = 0;
  int n10    = 0;
  int nrej   = 0;
  int nbad   = 0;
  int njam   = 0;
  int t_evt  = -1;
  int t_idle = -1;

  coin_validator #(
    .MIN5(4), .MAX5(8), .MIN10(12), .MAX10(20), .GAP(GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .coin_sense (coin_sense),
    .inhibit    (inhibit),
    .in_code    (in_code),
    .reject     (reject),
    .jam        (jam),
    .busy       (busy)
`ifdef COIN_AUDIT_EN
    ,
    .cnt5       (cnt5),
    .cnt10      (cnt10)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (in_code == 2'b01) begin n5++;  t_evt = cyc; end
    if (in_code == 2'b10) begin n10++; t_evt = cyc; end
    if (reject)           begin nrej++; t_evt = cyc; end
    if ((in_code == 2'b11) || ((in_code != 2'b00) && reject)) nbad++;
    if (jam) njam++;
    if ((t_evt >= 0) && (t_idle < 0) && !busy) t_idle = cyc;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic clear_mon();
    @(posedge clk);
    n5 = 0; n10 = 0; nrej = 0; nbad = 0; njam = 0;
    t_evt = -1; t_idle = -1;
  endtask

  // One coin of 'width' cycles; checks pulse counts and lockout length
  // (cycles from the event pulse until busy is low).
  task automatic run_coin(input string tag, input int width, input logic inh,
                          input int e5, input int e10, input int erej,
                          input int ejam, input int egap);
    int k;
    clear_mon();
    @(negedge clk);
    coin_sense = 1'b1;
    inhibit    = inh;
    repeat (width) @(negedge clk);
    coin_sense = 1'b0;
    k = 0;
    while ((t_idle < 0) && (k < 100)) begin
      @(negedge clk);
      k++;
    end
    inhibit = 1'b0;
    check_eq({tag, "_done"}, int'(t_idle >= 0), 1);
    check_eq({tag, "_n5"},   n5,   e5);
    check_eq({tag, "_n10"},  n10,  e10);
    check_eq({tag, "_nrej"}, nrej, erej);
    check_eq({tag, "_bad"},  nbad, 0);
    check_eq({tag, "_jam"},  int'(njam > 0), ejam);
    check_eq({tag, "_gap"},  t_idle - t_evt, egap);
  endtask

  initial begin
`ifdef COIN_AUDIT_EN
    int c10_before;
`endif
    rst        = 1'b1;
    coin_sense = 1'b0;
    inhibit    = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_code",   int'(in_code), 0);
    check_eq("rst_reject", int'(reject),  0);
    check_eq("rst_jam",    int'(jam),     0);
    check_eq("rst_busy",   int'(busy),    0);
`ifdef COIN_AUDIT_EN
    check_eq("rst_cnt5",  int'(cnt5),  0);
    check_eq("rst_cnt10", int'(cnt10), 0);
`endif
    rst = 1'b0;
    repeat (2) @(negedge clk);

    //        tag       width inh  n5 n10 rej jam gap
    run_coin("w6",      6,   1'b0, 1, 0, 0, 0, GAP + 1);
    run_coin("w4",      4,   1'b0, 1, 0, 0, 0, GAP + 1);
    run_coin("w8",      8,   1'b0, 1, 0, 0, 0, GAP + 1);
    run_coin("w3",      3,   1'b0, 0, 0, 1, 0, GAP + 1);
    run_coin("w9",      9,   1'b0, 0, 0, 1, 0, GAP + 1);
    run_coin("w12",     12,  1'b0, 0, 1, 0, 0, GAP + 1);
    run_coin("w20",     20,  1'b0, 0, 1, 0, 0, GAP + 1);
    run_coin("w10",     10,  1'b0, 0, 0, 1, 0, GAP + 1);
    run_coin("w11",     11,  1'b0, 0, 0, 1, 0, GAP + 1);
    run_coin("w21",     21,  1'b0, 0, 0, 1, 0, GAP + 1);
    run_coin("w6_inh",  6,   1'b1, 0, 0, 1, 0, GAP + 1);
`ifdef COIN_AUDIT_EN
    c10_before = int'(cnt10);
`endif
    run_coin("w15_inh", 15,  1'b1, 0, 0, 1, 0, GAP + 1);
`ifdef COIN_AUDIT_EN
    check_eq("inh_cnt10", int'(cnt10), c10_before);
`endif
    // Jam: reject pulse comes with the first lockout cycle, so busy drops
    // GAP cycles after it.
    run_coin("jam300",  300, 1'b0, 0, 0, 1, 1, GAP);

    // Reset in the middle of a width-5 coin
    clear_mon();
    @(negedge clk);
    coin_sense = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("mid_busy_pre", int'(busy), 1);
    #1 rst = 1'b1;
    #1;
    check_eq("mid_rst_busy", int'(busy), 0);
    check_eq("mid_rst_code", int'(in_code), 0);
    check_eq("mid_rst_rej",  int'(reject), 0);
    coin_sense = 1'b0;
    repeat (2) @(negedge clk);
    clear_mon();
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("post_rst_n5",   n5,   0);
    check_eq("post_rst_n10",  n10,  0);
    check_eq("post_rst_nrej", nrej, 0);
    check_eq("post_rst_busy", int'(busy), 0);
    run_coin("after_rst", 6, 1'b0, 1, 0, 0, 0, GAP + 1);

`ifdef COIN_AUDIT_EN
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 260; i++) begin
      @(negedge clk);
      coin_sense = 1'b1;
      repeat (6) @(negedge clk);
      coin_sense = 1'b0;
      repeat (15) @(negedge clk);
    end
    check_eq("sat_cnt5",  int'(cnt5),  255);
    check_eq("sat_cnt10", int'(cnt10), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
